// File: rtl/dut_xfer_pkg.sv
// Shared types, default widths and sizing helper for the DUT transfer controller.
package dut_xfer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    RECV,
    DONE,
    ERR
  } xfer_st_e;

  localparam int DEF_W        = 64;
  localparam int DEF_OUTPUT_W = 4;
  localparam int DEF_COEFF_W  = 23;

  // Beat counter must hold the value pBEATS itself, hence one bit above the index.
  function automatic int beat_cnt_w(input int beats);
    return $clog2(beats) + 1;
  endfunction

endpackage

// File: rtl/dut_xfer_timer.sv
// Stall counter: counts idle cycles and flags when the configured limit is reached.
module dut_xfer_timer #(
  parameter int pTMO_W = 16
) (
  input  logic              usb_clk,
  input  logic              reset_i,
  input  logic              clear,
  input  logic              enable,
  input  logic [pTMO_W-1:0] limit,
  output logic              expired
);

  logic [pTMO_W-1:0] count;
  logic [pTMO_W-1:0] count_inc;

  assign count_inc = count + pTMO_W'(1);

  // Raised on the cycle whose increment reaches the limit, so a stall lasts exactly
  // `limit` cycles before the controller gives up. Zero limit never expires.
  assign expired = (limit != '0) && (count_inc == limit);

  always_ff @(posedge usb_clk or posedge reset_i) begin
    if (reset_i)     count <= '0;
    else if (clear)  count <= '0;
    else if (enable) count <= count_inc;
  end

endmodule

// File: rtl/dut_xfer_ctrl.sv
// Host-driven transfer controller: sends one word to the DUT, captures pBEATS output
// beats into a small buffer, with stall timeout, abort and a registered read port.
module dut_xfer_ctrl
  import dut_xfer_pkg::*;
#(
  parameter int pW        = DEF_W,
  parameter int pOUTPUT_W = DEF_OUTPUT_W,
  parameter int pCOEFF_W  = DEF_COEFF_W,
  parameter int pBEATS    = 8,
  parameter int pTMO_W    = 16
) (
  input  logic                              usb_clk,
  input  logic                              reset_i,
  input  logic                              i_start,
  input  logic                              i_abort,
  input  logic [pW-1:0]                     i_di,
  input  logic [pTMO_W-1:0]                 i_tmo_limit,
  output logic                              VALID_TO_DUT,
  output logic [pW-1:0]                     o_data_to_dut,
  input  logic                              READY_FROM_DUT,
  input  logic                              VALID_FROM_DUT,
  input  logic [pOUTPUT_W*pCOEFF_W-1:0]     i_samples,
  output logic                              READY_TO_DUT,
  output logic                              o_busy,
  output logic                              o_done,
  output logic                              o_timeout,
  output logic [beat_cnt_w(pBEATS)-1:0]     o_beat_cnt,
  input  logic [$clog2(pBEATS)-1:0]         i_rd_idx,
  output logic [pOUTPUT_W*pCOEFF_W-1:0]     o_rd_data
);

  localparam int SW    = pOUTPUT_W * pCOEFF_W;
  localparam int IDX_W = $clog2(pBEATS);
  localparam int CNT_W = beat_cnt_w(pBEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(pBEATS - 1);

  xfer_st_e state, state_nxt;
  logic     start_acc, send_hs, beat_acc;
  logic     tmr_clr, tmr_en, tmr_exp;

  logic [SW-1:0] buf_mem [pBEATS];

  always_ff @(posedge usb_clk or posedge reset_i) begin
    if (reset_i) state <= IDLE;
    else         state <= state_nxt;
  end

  // Abort overrides everything, including a start in the same cycle.
  always_comb begin
    state_nxt = state;
    start_acc = 1'b0;
    send_hs   = 1'b0;
    beat_acc  = 1'b0;
    tmr_en    = 1'b0;
    if (i_abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE, DONE, ERR: begin
          if (i_start) begin
            start_acc = 1'b1;
            state_nxt = SEND;
          end
        end
        SEND: begin
          if (READY_FROM_DUT) begin
            send_hs   = 1'b1;
            state_nxt = RECV;
          end else begin
            tmr_en = 1'b1;
            if (tmr_exp) state_nxt = ERR;
          end
        end
        RECV: begin
          if (VALID_FROM_DUT) begin
            beat_acc = 1'b1;
            if (o_beat_cnt == LAST_BEAT) state_nxt = DONE;
          end else begin
            tmr_en = 1'b1;
            if (tmr_exp) state_nxt = ERR;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Any handshake restarts the stall window, so a handshake always beats a timeout.
  assign tmr_clr = i_abort | start_acc | send_hs | beat_acc;

  dut_xfer_timer #(
    .pTMO_W (pTMO_W)
  ) u_timer (
    .usb_clk (usb_clk),
    .reset_i (reset_i),
    .clear   (tmr_clr),
    .enable  (tmr_en),
    .limit   (i_tmo_limit),
    .expired (tmr_exp)
  );

  assign VALID_TO_DUT = (state == SEND);
  assign READY_TO_DUT = (state == RECV);
  assign o_busy       = (state == SEND) || (state == RECV);
  assign o_done       = (state == DONE);
  assign o_timeout    = (state == ERR);

  always_ff @(posedge usb_clk or posedge reset_i) begin
    if (reset_i)                   o_beat_cnt <= '0;
    else if (i_abort || start_acc) o_beat_cnt <= '0;
    else if (beat_acc)             o_beat_cnt <= o_beat_cnt + CNT_W'(1);
  end

  always_ff @(posedge usb_clk or posedge reset_i) begin
    if (reset_i)        o_data_to_dut <= '0;
    else if (start_acc) o_data_to_dut <= i_di;
  end

  // Buffer has no reset so it maps onto distributed RAM; contents survive abort.
  always_ff @(posedge usb_clk) begin
    if (beat_acc) buf_mem[o_beat_cnt[IDX_W-1:0]] <= i_samples;
  end

  always_ff @(posedge usb_clk or posedge reset_i) begin
    if (reset_i) o_rd_data <= '0;
    else         o_rd_data <= buf_mem[i_rd_idx];
  end

endmodule

// File: tb/tb_dut_xfer_ctrl.sv
// Directed and random stimulus against a transaction-level model of the transfer controller.
module tb_dut_xfer_ctrl;

  localparam int W     = 64;
  localparam int OW    = 4;
  localparam int CW    = 23;
  localparam int SW    = OW * CW;
  localparam int BEATS = 8;
  localparam int TW    = 16;
  localparam int IW    = 3;
  localparam int CNTW  = 4;

  logic          usb_clk = 1'b0;
  logic          reset_i = 1'b0;
  logic          i_start, i_abort;
  logic [W-1:0]  i_di;
  logic [TW-1:0] i_tmo_limit;
  logic          VALID_TO_DUT;
  logic [W-1:0]  o_data_to_dut;
  logic          READY_FROM_DUT, VALID_FROM_DUT;
  logic [SW-1:0] i_samples;
  logic          READY_TO_DUT, o_busy, o_done, o_timeout;
  logic [CNTW-1:0] o_beat_cnt;
  logic [IW-1:0] i_rd_idx;
  logic [SW-1:0] o_rd_data;

  always #5 usb_clk = ~usb_clk;

  dut_xfer_ctrl #(
    .pW(W), .pOUTPUT_W(OW), .pCOEFF_W(CW), .pBEATS(BEATS), .pTMO_W(TW)
  ) dut (
    .usb_clk(usb_clk), .reset_i(reset_i), .i_start(i_start), .i_abort(i_abort),
    .i_di(i_di), .i_tmo_limit(i_tmo_limit), .VALID_TO_DUT(VALID_TO_DUT),
    .o_data_to_dut(o_data_to_dut), .READY_FROM_DUT(READY_FROM_DUT),
    .VALID_FROM_DUT(VALID_FROM_DUT), .i_samples(i_samples), .READY_TO_DUT(READY_TO_DUT),
    .o_busy(o_busy), .o_done(o_done), .o_timeout(o_timeout), .o_beat_cnt(o_beat_cnt),
    .i_rd_idx(i_rd_idx), .o_rd_data(o_rd_data)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Transaction-level model: phase, captured beats, stall length, buffer image.
  typedef enum {M_IDLE, M_SEND, M_RECV, M_DONE, M_ERR} mph_e;
  mph_e          ph;
  int            mcnt, stall;
  logic [W-1:0]  mdata;
  logic [SW-1:0] mbuf [BEATS];
  bit            mval [BEATS];
  logic [SW-1:0] mrd;
  bit            mrd_ok;

  task automatic model_reset();
    ph = M_IDLE; mcnt = 0; stall = 0; mdata = '0; mrd = '0; mrd_ok = 1'b1;
    for (int i = 0; i < BEATS; i++) mval[i] = 1'b0;
  endtask

  function automatic bit stalled_out();
    return (i_tmo_limit != '0) && (stall == int'(i_tmo_limit));
  endfunction

  task automatic model_step();
    mrd_ok = mval[i_rd_idx];
    mrd    = mbuf[i_rd_idx];
    if (i_abort) begin
      ph = M_IDLE; mcnt = 0; stall = 0;
    end else begin
      case (ph)
        M_IDLE, M_DONE, M_ERR:
          if (i_start) begin ph = M_SEND; mdata = i_di; mcnt = 0; stall = 0; end
        M_SEND:
          if (READY_FROM_DUT) begin ph = M_RECV; stall = 0; end
          else begin stall++; if (stalled_out()) ph = M_ERR; end
        M_RECV:
          if (VALID_FROM_DUT) begin
            mbuf[mcnt] = i_samples; mval[mcnt] = 1'b1; mcnt++; stall = 0;
            if (mcnt == BEATS) ph = M_DONE;
          end else begin stall++; if (stalled_out()) ph = M_ERR; end
        default: ph = M_IDLE;
      endcase
    end
  endtask

  task automatic check_all();
    chk("ctrl", 128'({VALID_TO_DUT, READY_TO_DUT, o_busy, o_done, o_timeout, o_beat_cnt}),
        128'({(ph == M_SEND), (ph == M_RECV), ((ph == M_SEND) || (ph == M_RECV)),
              (ph == M_DONE), (ph == M_ERR), CNTW'(mcnt)}));
    chk("data", 128'(o_data_to_dut), 128'(mdata));
    if (mrd_ok) chk("rd", 128'(o_rd_data), 128'(mrd));
  endtask

  task automatic cyc();
    @(posedge usb_clk);
    model_step();
    @(negedge usb_clk);
    check_all();
  endtask

  task automatic idle_in();
    i_start = 1'b0; i_abort = 1'b0; READY_FROM_DUT = 1'b0; VALID_FROM_DUT = 1'b0;
  endtask

  task automatic do_reset(input bit hold_start);
    idle_in();
    i_start = hold_start;
    @(negedge usb_clk);
    #2 reset_i = 1'b1;
    #1;
    chk("rst_ctrl", 128'({VALID_TO_DUT, READY_TO_DUT, o_busy, o_done, o_timeout, o_beat_cnt}), 128'(0));
    chk("rst_data", 128'(o_data_to_dut), 128'(0));
    chk("rst_rd", 128'(o_rd_data), 128'(0));
    model_reset();
    repeat (2) @(posedge usb_clk);
    @(negedge usb_clk);
    i_start = 1'b0;
    reset_i = 1'b0;
  endtask

  task automatic xfer(input logic [W-1:0] di, input int base, input int rdy_dly);
    i_di = di; i_start = 1'b1; cyc(); i_start = 1'b0;
    repeat (rdy_dly) cyc();
    READY_FROM_DUT = 1'b1; cyc(); READY_FROM_DUT = 1'b0;
    for (int k = 0; k < BEATS; k++) begin
      VALID_FROM_DUT = 1'b1; i_samples = SW'(base + k); cyc();
    end
    VALID_FROM_DUT = 1'b0;
  endtask

  initial begin
    idle_in();
    i_di = '0; i_tmo_limit = '0; i_samples = '0; i_rd_idx = '0;
    model_reset();
    do_reset(1'b0);
    cyc();

    // nominal transfer
    i_tmo_limit = '0;
    i_di = 64'h0123456789ABCDEF; i_start = 1'b1; cyc(); i_start = 1'b0;
    chk("nom_vtd", 128'(VALID_TO_DUT), 128'(1));
    repeat (3) cyc();
    READY_FROM_DUT = 1'b1; cyc(); READY_FROM_DUT = 1'b0;
    for (int k = 0; k < BEATS; k++) begin
      VALID_FROM_DUT = 1'b1; i_samples = SW'(k); cyc();
      if (k == BEATS - 2) chk("nom_busy_b6", 128'(o_busy), 128'(1));
    end
    VALID_FROM_DUT = 1'b0;
    chk("nom_busy_end", 128'(o_busy), 128'(0));
    chk("nom_done", 128'(o_done), 128'(1));
    chk("nom_cnt", 128'(o_beat_cnt), 128'(8));
    i_rd_idx = 3'd5; cyc();
    chk("nom_rd5", 128'(o_rd_data), 128'(5));

    // backpressure with a short limit
    i_tmo_limit = 16'd4;
    i_di = 64'hFEED; i_start = 1'b1; cyc(); i_start = 1'b0;
    READY_FROM_DUT = 1'b1; cyc(); READY_FROM_DUT = 1'b0;
    for (int k = 0; k < BEATS; k++) begin
      VALID_FROM_DUT = 1'b1; i_samples = SW'(100 + k); cyc();
      VALID_FROM_DUT = 1'b0; cyc();
    end
    chk("bp_tmo", 128'(o_timeout), 128'(0));
    chk("bp_done", 128'(o_done), 128'(1));
    for (int k = 0; k < BEATS; k++) begin
      i_rd_idx = IW'(k); cyc();
      chk("bp_order", 128'(o_rd_data), 128'(100 + k));
    end

    // timeout after exactly 10 stalled cycles
    begin
      int vh;
      vh = 0;
      i_tmo_limit = 16'd10;
      i_start = 1'b1; cyc(); i_start = 1'b0;
      for (int i = 0; i < 30; i++) begin
        if (VALID_TO_DUT) vh++;
        if (o_timeout) break;
        cyc();
      end
      chk("tmo_len", 128'(vh), 128'(10));
      chk("tmo_flag", 128'(o_timeout), 128'(1));
      chk("tmo_vtd", 128'(VALID_TO_DUT), 128'(0));
    end

    // timeout disabled across a counter wrap
    i_tmo_limit = '0;
    i_start = 1'b1; cyc(); i_start = 1'b0;
    READY_FROM_DUT = 1'b1; cyc(); READY_FROM_DUT = 1'b0;
    repeat (70000) cyc();
    chk("nodis_busy", 128'(o_busy), 128'(1));
    i_abort = 1'b1; cyc(); i_abort = 1'b0;

    // abort mid-receive keeps the buffer
    i_start = 1'b1; cyc(); i_start = 1'b0;
    READY_FROM_DUT = 1'b1; cyc(); READY_FROM_DUT = 1'b0;
    for (int k = 0; k < 3; k++) begin
      VALID_FROM_DUT = 1'b1; i_samples = SW'(32'hA0 + k); cyc();
    end
    VALID_FROM_DUT = 1'b0;
    i_abort = 1'b1; cyc(); i_abort = 1'b0;
    chk("abt_cnt", 128'(o_beat_cnt), 128'(0));
    chk("abt_busy", 128'(o_busy), 128'(0));
    i_rd_idx = 3'd2; cyc();
    chk("abt_buf2", 128'(o_rd_data), 128'(32'hA2));

    // start and abort together
    i_start = 1'b1; i_abort = 1'b1; cyc(); i_start = 1'b0; i_abort = 1'b0;
    chk("sa_busy", 128'(o_busy), 128'(0));
    chk("sa_vtd", 128'(VALID_TO_DUT), 128'(0));

    // restart from DONE, start while busy ignored
    xfer(64'h1111, 32'h200, 1);
    chk("rs_done1", 128'(o_done), 128'(1));
    i_di = 64'h2222; i_start = 1'b1; cyc(); i_start = 1'b0;
    chk("rs_done_clr", 128'(o_done), 128'(0));
    i_di = 64'h3333; i_start = 1'b1; cyc(); i_start = 1'b0;
    chk("rs_ign", 128'(o_data_to_dut), 128'(64'h2222));
    READY_FROM_DUT = 1'b1; cyc(); READY_FROM_DUT = 1'b0;
    for (int k = 0; k < BEATS; k++) begin
      VALID_FROM_DUT = 1'b1; i_samples = SW'(32'h300 + k); cyc();
    end
    VALID_FROM_DUT = 1'b0;
    chk("rs_done2", 128'(o_done), 128'(1));

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 63) == 0) i_tmo_limit = TW'($urandom_range(0, 12));
      i_start        = ($urandom_range(0, 9) == 0);
      i_abort        = ($urandom_range(0, 49) == 0);
      READY_FROM_DUT = ($urandom_range(0, 1) == 0);
      VALID_FROM_DUT = ($urandom_range(0, 4) != 0);
      i_di           = {$urandom(), $urandom()};
      i_samples      = SW'({$urandom(), $urandom(), $urandom()});
      i_rd_idx       = IW'($urandom_range(0, BEATS - 1));
      cyc();
    end
    idle_in();

    // reset mid-transaction with start held; no replay afterwards
    i_tmo_limit = '0;
    i_start = 1'b1; cyc(); i_start = 1'b0;
    READY_FROM_DUT = 1'b1; cyc(); READY_FROM_DUT = 1'b0;
    VALID_FROM_DUT = 1'b1; i_samples = SW'(7); cyc(); cyc();
    do_reset(1'b1);
    repeat (3) cyc();
    chk("rst_norep", 128'(o_busy), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dut_xfer_ctrl.md
DUT_XFER_CTRL -- requirements
Module: dut_xfer_ctrl

Interface
REQ-001 SHALL have parameter pW, default 64, meaning the width of the input data word sent to the DUT.
REQ-002 SHALL have parameter pOUTPUT_W, default 4, meaning the number of coefficients per DUT output beat.
REQ-003 SHALL have parameter pCOEFF_W, default 23, meaning the width of one coefficient.
REQ-004 SHALL have parameter pBEATS, default 8, meaning the number of output beats captured per transaction (power of 2, at least 2).
REQ-005 SHALL have parameter pTMO_W, default 16, meaning the width of the timeout counter and limit.
REQ-006 SHALL use one clock, usb_clk; reset is asynchronous and active-high, reset_i.
REQ-007 Ports (name, direction, width, meaning):
- usb_clk, in, 1: clock.
- reset_i, in, 1: async active-high reset.
- i_start, in, 1: one-cycle start pulse from the host register file.
- i_abort, in, 1: one-cycle abort pulse.
- i_di, in, pW: data word, latched at an accepted start.
- i_tmo_limit, in, pTMO_W: stall limit in cycles; 0 disables the timeout.
- VALID_TO_DUT, out, 1: input-word valid.
- o_data_to_dut, out, pW: latched input word.
- READY_FROM_DUT, in, 1: DUT accepts the input word.
- VALID_FROM_DUT, in, 1: DUT output beat valid.
- i_samples, in, pOUTPUT_W*pCOEFF_W: DUT output beat.
- READY_TO_DUT, out, 1: controller accepts an output beat.
- o_busy, out, 1: transaction in progress.
- o_done, out, 1: all beats captured (sticky).
- o_timeout, out, 1: transaction stalled (sticky).
- o_beat_cnt, out, log2(pBEATS)+1: number of beats captured.
- i_rd_idx, in, log2(pBEATS): buffer read index.
- o_rd_data, out, pOUTPUT_W*pCOEFF_W: buffer word at the registered read index.

Function
REQ-008 SHALL implement the FSM states IDLE, SEND, RECV, DONE and ERR.
REQ-009 In IDLE, DONE or ERR, an i_start pulse SHALL move the FSM to SEND, latch i_di, and clear o_beat_cnt, o_done, o_timeout and the timer.
REQ-010 An i_start pulse in SEND or RECV SHALL be ignored.
REQ-011 VALID_TO_DUT SHALL be 1 exactly in SEND, asserting in the cycle after the accepted start.
- o_data_to_dut SHALL be stable while VALID_TO_DUT is 1.
REQ-012 In SEND, VALID_TO_DUT & READY_FROM_DUT SHALL move the FSM to RECV in the next cycle.
REQ-013 READY_TO_DUT SHALL be 1 exactly in RECV.
- Beats presented in any other state SHALL be dropped.
REQ-014 In RECV, each cycle with VALID_FROM_DUT=1 SHALL:
- write i_samples to buffer[o_beat_cnt];
- increment o_beat_cnt.
REQ-015 Acceptance of beat pBEATS-1 SHALL move the FSM to DONE in the next cycle, with o_done=1 and o_beat_cnt=pBEATS; the count SHALL NOT wrap.
REQ-016 o_busy SHALL be 1 exactly in SEND and RECV.
REQ-017 Timer rules:
- The timer SHALL be cleared on entry to SEND or RECV and on every handshake.
- It SHALL increment on every other cycle in SEND and RECV.
- When i_tmo_limit!=0 and the timer equals i_tmo_limit, the FSM SHALL move to ERR, with o_timeout=1.
REQ-018 Timeout and handshake in the same cycle: the handshake SHALL win.
REQ-019 i_abort SHALL move the FSM from any state to IDLE in the next cycle, clearing o_busy, o_done, o_timeout and o_beat_cnt; the buffer contents SHALL be retained.
REQ-020 i_abort and i_start in the same cycle: abort SHALL win and start SHALL be dropped.
REQ-021 o_rd_data SHALL equal buffer[i_rd_idx] one cycle after i_rd_idx is sampled (registered read).
REQ-022 All state changes SHALL occur on the rising edge of usb_clk.

Reset
REQ-023 While reset_i=1, asynchronously:
- FSM SHALL be IDLE.
- VALID_TO_DUT, READY_TO_DUT, o_busy, o_done and o_timeout SHALL be 0.
- o_beat_cnt, o_data_to_dut and o_rd_data SHALL be 0.
- The timer SHALL be 0.
REQ-024 Buffer contents SHALL be unspecified after reset.
REQ-025 Reset asserted mid-transaction SHALL abandon the transaction; no start SHALL be replayed after reset release.

Structure
REQ-026 Package dut_xfer_pkg SHALL hold:
- the FSM state enum;
- the default widths (pW, pOUTPUT_W, pCOEFF_W);
- the beat-counter width function.
REQ-027 The timeout counter SHALL be the sub-module dut_xfer_timer, with ports clear, enable, limit and expired.
REQ-028 The buffer SHALL be inferred distributed RAM inside dut_xfer_ctrl.

Verification
REQ-029 Nominal: i_di=64'h0123456789ABCDEF, start, READY_FROM_DUT after 3 cycles, 8 beats with i_samples=beat index -> o_done=1, o_beat_cnt=8, o_rd_data(idx 5)=5, o_busy low exactly 1 cycle after beat 7.
REQ-030 Backpressure: VALID_FROM_DUT toggled 1,0,1,0 with i_tmo_limit=4 -> no timeout, beats stored in order.
REQ-031 Timeout: i_tmo_limit=10, READY_FROM_DUT held 0 -> ERR with o_timeout=1 exactly 10 cycles after VALID_TO_DUT rises; VALID_TO_DUT=0 next cycle.
REQ-032 Timeout disabled: i_tmo_limit=0, DUT silent for 70000 cycles -> o_busy stays 1.
REQ-033 Abort, start+abort: abort during RECV after 3 beats -> IDLE, o_beat_cnt=0, buffer[2] intact. Start and abort in the same cycle -> FSM stays IDLE.
REQ-034 Restart and ignore: start in DONE -> o_done clears and a new transaction completes. Start while busy -> no effect on o_data_to_dut.
